wb_fwd_tracker: RTL and testbench

Producer-side tracker for operand forwarding in the 3-stage RISC-V pipeline. It records the destination register and result of each instruction leaving stage 3 and, for the stage-2 instruction, returns forwarded rs1/rs2 values plus hit flags. It stalls stage 2 when the producer is a load whose data has not yet returned. It is the data-source end of the forwarding path, complementing the stage-2 select logic.

---
 rtl/wb_fwd_tracker.sv | 182 ++++++++++++++++++
 tb/tb_wb_fwd_tracker.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_fwd_tracker.sv
// wb_fwd_tracker: producer-side operand forwarding source for the 3-stage pipeline.
// Tracks the instruction leaving stage 3 (one entry) and supplies forwarded
// rs1/rs2 values for the stage-2 consumer. It stalls stage 2 while a load's
// data is outstanding.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   ex_inst/ex_valid     stage-3 instruction and its valid bit
//   ex_result            stage-3 result for non-load producers
//   mem_rdata/mem_valid  returning load data and its valid bit
//   flush                kill stage 3 and the tracked entry
//   dec_inst             stage-2 (consumer) instruction
//   rs1_hit/rs1_data     forwarded rs1 (combinational)
//   rs2_hit/rs2_data     forwarded rs2 (combinational)
//   stall                hold stages 1/2 (combinational)
//   stall_count          saturating count of stall cycles (registered)
module wb_fwd_tracker (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ex_inst,
    input  logic        ex_valid,
    input  logic [31:0] ex_result,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid,
    input  logic        flush,
    input  logic [31:0] dec_inst,
    output logic        rs1_hit,
    output logic [31:0] rs1_data,
    output logic        rs2_hit,
    output logic [31:0] rs2_data,
    output logic        stall,
    output logic [31:0] stall_count
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned N_SRC = 2;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_READY   = 2'd1,
        ST_PENDING = 2'd2
    } ent_state_e;

    ent_state_e             state_q, state_d;
    logic [REG_W-1:0]       rd_q, rd_d;
    logic [XLEN-1:0]        data_q, data_d;
    logic [XLEN-1:0]        stall_count_q, stall_count_d;

    logic [6:0]             ex_opc;
    logic [REG_W-1:0]       ex_rd;
    logic                   ex_is_load;
    logic                   ex_live;
    logic [6:0]             dec_opc;
    logic [N_SRC-1:0]       src_used;
    logic [N_SRC-1:0][REG_W-1:0] src_idx;
    logic [N_SRC-1:0]       src_hit;
    logic [N_SRC-1:0]       src_stl;
    logic [N_SRC-1:0][XLEN-1:0]  src_data;
    logic                   advance;
    logic                   stall_raw;

    // Fields of the instruction words that no rule looks at.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{ex_inst[31:12], dec_inst[31:25], dec_inst[13:7]};

    // Producer decode; a flushed stage-3 instruction is treated as absent.
    always_comb begin
        ex_opc     = ex_inst[6:0];
        ex_rd      = ex_inst[11:7];
        ex_is_load = (ex_opc == OPC_LOAD);
        ex_live    = ex_valid && !flush && (ex_opc != OPC_BRANCH)
                     && (ex_opc != OPC_STORE) && (ex_rd != '0);
    end

    // Consumer decode.
    always_comb begin
        dec_opc    = dec_inst[6:0];
        src_idx[0] = dec_inst[19:15];
        src_idx[1] = dec_inst[24:20];
        unique case (dec_opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL: src_used[0] = 1'b0;
            OPC_SYSTEM:                  src_used[0] = !dec_inst[14];
            default:                     src_used[0] = 1'b1;
        endcase
        src_used[1] = (dec_opc == OPC_OP) || (dec_opc == OPC_BRANCH)
                      || (dec_opc == OPC_STORE);
    end

    // A pending load blocks the entry from being overwritten.
    assign advance = !((state_q == ST_PENDING) && !mem_valid);

    // Per-operand source selection: stage 3 beats the entry.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            src_hit[i]  = 1'b0;
            src_stl[i]  = 1'b0;
            src_data[i] = '0;
            if (src_used[i] && (src_idx[i] != '0)) begin
                if (ex_live && (ex_rd == src_idx[i])) begin
                    if (ex_is_load) begin
                        src_stl[i] = 1'b1;
                    end else begin
                        src_hit[i]  = 1'b1;
                        src_data[i] = ex_result;
                    end
                end else if ((state_q != ST_EMPTY) && (rd_q == src_idx[i])) begin
                    if (state_q == ST_READY) begin
                        src_hit[i]  = 1'b1;
                        src_data[i] = data_q;
                    end else if (mem_valid) begin
                        src_hit[i]  = 1'b1;
                        src_data[i] = mem_rdata;
                    end else begin
                        src_stl[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Outputs are held quiet while reset is asserted.
    always_comb begin
        stall_raw = (|src_stl) || !advance;
        rs1_hit   = !rst && src_hit[0];
        rs2_hit   = !rst && src_hit[1];
        rs1_data  = rst ? '0 : src_data[0];
        rs2_data  = rst ? '0 : src_data[1];
        stall     = !rst && stall_raw;
    end

    // Entry and stall counter next state.
    always_comb begin
        state_d       = state_q;
        rd_d          = rd_q;
        data_d        = data_q;
        stall_count_d = stall_count_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (advance) begin
            if (ex_live) begin
                rd_d = ex_rd;
                if (ex_is_load) begin
                    state_d = ST_PENDING;
                end else begin
                    state_d = ST_READY;
                    data_d  = ex_result;
                end
            end else begin
                state_d = ST_EMPTY;
            end
        end
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + XLEN'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_EMPTY;
            rd_q          <= '0;
            data_q        <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            rd_q          <= rd_d;
            data_q        <= data_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_wb_fwd_tracker.sv
// Self-checking bench for wb_fwd_tracker: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// forwarding rules.
module tb_wb_fwd_tracker;
    logic        clk;
    logic        rst;
    logic [31:0] ex_inst;
    logic        ex_valid;
    logic [31:0] ex_result;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        flush;
    logic [31:0] dec_inst;
    logic        rs1_hit;
    logic [31:0] rs1_data;
    logic        rs2_hit;
    logic [31:0] rs2_data;
    logic        stall;
    logic [31:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model of the last producer: 0 none, 1 value known, 2 waiting on load data.
    int          m_kind;
    logic [4:0]  m_reg;
    logic [31:0] m_val;
    longint      m_cnt;

    wb_fwd_tracker dut (
        .clk(clk), .rst(rst), .ex_inst(ex_inst), .ex_valid(ex_valid),
        .ex_result(ex_result), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .flush(flush), .dec_inst(dec_inst), .rs1_hit(rs1_hit), .rs1_data(rs1_data),
        .rs2_hit(rs2_hit), .rs2_data(rs2_data), .stall(stall), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction builders.
    function automatic logic [31:0] i_add(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        return {7'b0, b, a, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] i_addi(input logic [4:0] rd, input logic [4:0] a);
        return {12'h001, a, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] i_lw(input logic [4:0] rd, input logic [4:0] a);
        return {12'h000, a, 3'b010, rd, 7'b0000011};
    endfunction
    function automatic logic [31:0] i_sw(input logic [4:0] b, input logic [4:0] a, input logic [4:0] imm);
        return {7'b0, b, a, 3'b010, imm, 7'b0100011};
    endfunction
    function automatic logic [31:0] i_beq(input logic [4:0] a, input logic [4:0] b, input logic [4:0] imm);
        return {7'b0, b, a, 3'b000, imm, 7'b1100011};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [4:0] rd, a, b;
        rd = 5'($urandom_range(0, 3));
        a  = 5'($urandom_range(0, 3));
        b  = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 10))
            0:       return i_add(rd, a, b);
            1:       return i_addi(rd, a);
            2:       return i_lw(rd, a);
            3:       return i_sw(b, a, rd);
            4:       return i_beq(a, b, rd);
            5:       return {20'h12345, rd, 7'b0110111};
            6:       return {20'h00abc, rd, 7'b0010111};
            7:       return {{15'h0, a}, rd, 7'b1101111};
            8:       return {12'h300, a, 3'b001, rd, 7'b1110011};
            9:       return {12'h300, a, 3'b101, rd, 7'b1110011};
            default: return {12'h004, a, 3'b000, rd, 7'b1100111};
        endcase
    endfunction

    // Instruction properties from the ISA, independent of the design.
    function automatic bit writes_reg(input logic [31:0] ins);
        return ins[6:0] != 7'b1100011 && ins[6:0] != 7'b0100011 && ins[11:7] != 5'd0;
    endfunction
    function automatic bit reads_rs1(input logic [31:0] ins);
        if (ins[6:0] == 7'b0110111 || ins[6:0] == 7'b0010111 || ins[6:0] == 7'b1101111) return 1'b0;
        if (ins[6:0] == 7'b1110011) return !ins[14];
        return 1'b1;
    endfunction
    function automatic bit reads_rs2(input logic [31:0] ins);
        return ins[6:0] == 7'b0110011 || ins[6:0] == 7'b1100011 || ins[6:0] == 7'b0100011;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected forwarding result for one source register.
    task automatic model_src(input bit used, input logic [4:0] r,
                             output bit hit, output logic [31:0] val, output bit wait_data);
        hit = 0; val = '0; wait_data = 0;
        if (!used || r == 5'd0) return;
        if (ex_valid && !flush && writes_reg(ex_inst) && ex_inst[11:7] == r) begin
            if (ex_inst[6:0] == 7'b0000011) wait_data = 1;
            else begin hit = 1; val = ex_result; end
        end else if (m_kind != 0 && m_reg == r) begin
            if (m_kind == 1) begin hit = 1; val = m_val; end
            else if (mem_valid) begin hit = 1; val = mem_rdata; end
            else wait_data = 1;
        end
    endtask

    // Settle mid-cycle, compare every output with the model, then advance the model.
    task automatic eval_cycle();
        bit h1, h2, w1, w2, e_stall;
        logic [31:0] v1, v2;
        #4;
        model_src(reads_rs1(dec_inst), dec_inst[19:15], h1, v1, w1);
        model_src(reads_rs2(dec_inst), dec_inst[24:20], h2, v2, w2);
        e_stall = w1 || w2 || (m_kind == 2 && !mem_valid);
        if (rst) begin h1 = 0; h2 = 0; v1 = '0; v2 = '0; e_stall = 0; end
        chk($sformatf("c%0d_rs1_hit", cyc), 32'(rs1_hit), 32'(h1));
        chk($sformatf("c%0d_rs1_data", cyc), rs1_data, v1);
        chk($sformatf("c%0d_rs2_hit", cyc), 32'(rs2_hit), 32'(h2));
        chk($sformatf("c%0d_rs2_data", cyc), rs2_data, v2);
        chk($sformatf("c%0d_stall", cyc), 32'(stall), 32'(e_stall));
        chk($sformatf("c%0d_stall_count", cyc), stall_count, 32'(m_cnt));
        if (rst) begin
            m_kind = 0; m_cnt = 0;
        end else begin
            if (e_stall && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (flush) m_kind = 0;
            else if (!(m_kind == 2 && !mem_valid)) begin
                if (ex_valid && writes_reg(ex_inst)) begin
                    m_reg = ex_inst[11:7];
                    if (ex_inst[6:0] == 7'b0000011) m_kind = 2;
                    else begin m_kind = 1; m_val = ex_result; end
                end else m_kind = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_inst = i_add(5'd20, 5'd21, 5'd22); ex_result = 32'h0;
        mem_valid = 0; mem_rdata = 32'h0; flush = 0; dec_inst = i_add(5'd23, 5'd24, 5'd25);
    endtask

    initial begin
        m_kind = 0; m_reg = '0; m_val = '0; m_cnt = 0;
        rst = 1; idle_inputs();
        tick();
        // Reset state, with a consumer that would otherwise stall.
        ex_valid = 1; ex_inst = i_lw(5'd7, 5'd1); dec_inst = i_add(5'd8, 5'd7, 5'd7);
        eval_cycle();
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_count", stall_count, 32'h0);
        tick();
        rst = 0; idle_inputs();

        // Stage-3 addi forwards to rs1.
        ex_valid = 1; ex_inst = i_addi(5'd1, 5'd0); ex_result = 32'h11;
        dec_inst = i_add(5'd3, 5'd1, 5'd2);
        eval_cycle();
        chk("s3_rs1_hit", 32'(rs1_hit), 32'h1);
        chk("s3_rs1_data", rs1_data, 32'h11);
        chk("s3_rs2_hit", 32'(rs2_hit), 32'h0);
        chk("s3_stall", 32'(stall), 32'h0);
        tick();

        // Entry forwards to store rs2.
        ex_inst = i_add(5'd5, 5'd9, 5'd9); ex_result = 32'h55; dec_inst = i_add(5'd9, 5'd10, 5'd11);
        eval_cycle(); tick();
        ex_inst = i_addi(5'd12, 5'd13); ex_result = 32'h1234; dec_inst = i_sw(5'd5, 5'd6, 5'd0);
        eval_cycle();
        chk("ent_rs2_hit", 32'(rs2_hit), 32'h1);
        chk("ent_rs2_data", rs2_data, 32'h55);
        tick();

        // Load-use: two stall cycles, then data on mem_valid.
        ex_inst = i_lw(5'd7, 5'd1); dec_inst = i_add(5'd8, 5'd7, 5'd7);
        eval_cycle();
        chk("lu_stall0", 32'(stall), 32'h1);
        tick();
        ex_valid = 0; ex_inst = i_add(5'd20, 5'd21, 5'd22);
        eval_cycle();
        chk("lu_stall1", 32'(stall), 32'h1);
        tick();
        mem_valid = 1; mem_rdata = 32'hDEAD_BEEF;
        eval_cycle();
        chk("lu_rs1_data", rs1_data, 32'hDEAD_BEEF);
        chk("lu_rs2_data", rs2_data, 32'hDEAD_BEEF);
        chk("lu_stall2", 32'(stall), 32'h0);
        tick();
        idle_inputs();
        eval_cycle();
        chk("lu_count", stall_count, 32'h2);
        tick();

        // Stage 3 wins over the entry.
        ex_valid = 1; ex_inst = i_addi(5'd4, 5'd0); ex_result = 32'hB;
        eval_cycle(); tick();
        ex_result = 32'hA; dec_inst = i_add(5'd1, 5'd4, 5'd0);
        eval_cycle();
        chk("prio_rs1_data", rs1_data, 32'hA);
        tick();

        // Non-writing producers never hit.
        ex_inst = i_add(5'd0, 5'd1, 5'd1); ex_result = 32'h77; dec_inst = i_add(5'd1, 5'd0, 5'd0);
        eval_cycle();
        chk("x0_rs1_hit", 32'(rs1_hit), 32'h0);
        tick();
        ex_inst = i_beq(5'd1, 5'd2, 5'd5); dec_inst = i_add(5'd1, 5'd5, 5'd5);
        eval_cycle();
        chk("beq_rs1_hit", 32'(rs1_hit), 32'h0);
        tick();
        ex_inst = i_sw(5'd1, 5'd2, 5'd5);
        eval_cycle();
        chk("sw_rs2_hit", 32'(rs2_hit), 32'h0);
        tick();

        // Flush hides stage 3 and clears the entry.
        ex_inst = i_addi(5'd9, 5'd0); ex_result = 32'h99; flush = 1; dec_inst = i_add(5'd1, 5'd9, 5'd0);
        eval_cycle();
        chk("flush_rs1_hit", 32'(rs1_hit), 32'h0);
        tick();
        flush = 0; ex_valid = 0;
        eval_cycle();
        chk("flush_ent_hit", 32'(rs1_hit), 32'h0);
        tick();

        // Flush beats mem_valid on a pending load.
        ex_valid = 1; ex_inst = i_lw(5'd7, 5'd1); dec_inst = i_add(5'd1, 5'd2, 5'd3);
        eval_cycle(); tick();
        flush = 1; mem_valid = 1; mem_rdata = 32'h1111_2222; ex_inst = i_addi(5'd7, 5'd0);
        eval_cycle(); tick();
        idle_inputs(); dec_inst = i_add(5'd8, 5'd7, 5'd7);
        eval_cycle();
        chk("flmv_rs1_hit", 32'(rs1_hit), 32'h0);
        chk("flmv_stall", 32'(stall), 32'h0);
        tick();

        // Reset while a load is pending.
        ex_valid = 1; ex_inst = i_lw(5'd7, 5'd1); dec_inst = i_add(5'd1, 5'd2, 5'd3);
        eval_cycle(); tick();
        ex_valid = 0; rst = 1; dec_inst = i_add(5'd8, 5'd7, 5'd7);
        eval_cycle(); tick();
        rst = 0;
        eval_cycle();
        chk("rstp_stall", 32'(stall), 32'h0);
        chk("rstp_count", stall_count, 32'h0);
        chk("rstp_rs1_hit", 32'(rs1_hit), 32'h0);
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            ex_inst   = rand_inst();
            ex_valid  = ($urandom_range(0, 9) < 8);
            ex_result = $urandom;
            mem_valid = ($urandom_range(0, 9) < 4);
            mem_rdata = $urandom;
            flush     = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 49) == 0);
            dec_inst  = rand_inst();
            eval_cycle();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
